// File: rtl/cg_ctrl.sv
// Idle-driven clock-gate controller: counts qualifying idle cycles, handshakes a sleep
// request with the subsystem, gates the domain clock, and restores it with a settling window.
module cg_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic auto_en,
    input  logic force_on,
    input  logic idle,
    input  logic wake_req,
    input  logic sleep_ack,
    output logic sleep_req,
    output logic cg_en,
    output logic gated,
    output logic ready
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REQ   = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
    localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic       qual_s;
    logic       exit_s;
    logic [3:0] outs_nxt_s;

    // Output vector {cg_en, sleep_req, gated, ready} for a state; anything odd keeps the clock on.
    function automatic logic [3:0] out_decode(input state_t s);
        logic [3:0] o;
        case (s)
            ST_RUN:   o = 4'b1001;
            ST_REQ:   o = 4'b1100;
            ST_GATED: o = 4'b0110;
            ST_WAKE:  o = 4'b1100;
            default:  o = 4'b1001;
        endcase
        return o;
    endfunction

    assign qual_s = auto_en & ~force_on & idle & ~wake_req;
    assign exit_s = wake_req | force_on | ~auto_en;

    // Next-state and shared counter update; the counter is cleared on every transition.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (qual_s) begin
                    if (cnt_r == IDLE_LAST) begin
                        cnt_nxt_s   = 8'd0;
                        state_nxt_s = ST_REQ;
                    end else begin
                        cnt_nxt_s = cnt_r + 8'd1;
                    end
                end else begin
                    cnt_nxt_s = 8'd0;
                end
            end
            ST_REQ: begin
                // Abort wins over an acknowledge arriving in the same cycle.
                if (!qual_s) begin
                    cnt_nxt_s   = 8'd0;
                    state_nxt_s = ST_RUN;
                end else if (sleep_ack) begin
                    cnt_nxt_s   = 8'd0;
                    state_nxt_s = ST_GATED;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_GATED: begin
                if (exit_s) begin
                    cnt_nxt_s   = 8'd0;
                    state_nxt_s = ST_WAKE;
                end else begin
                    state_nxt_s = ST_GATED;
                end
            end
            ST_WAKE: begin
                if (cnt_r == WAKE_LAST) begin
                    cnt_nxt_s   = 8'd0;
                    state_nxt_s = ST_RUN;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                cnt_nxt_s   = 8'd0;
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    assign outs_nxt_s = out_decode(state_nxt_s);

    // FSM state, counter and registered outputs decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_RUN;
            cnt_r     <= 8'd0;
            cg_en     <= 1'b1;
            sleep_req <= 1'b0;
            gated     <= 1'b0;
            ready     <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            cg_en     <= outs_nxt_s[3];
            sleep_req <= outs_nxt_s[2];
            gated     <= outs_nxt_s[1];
            ready     <= outs_nxt_s[0];
        end
    end

endmodule

// File: tb/tb_cg_ctrl.sv
// Self-checking bench for cg_ctrl: directed scenarios plus randomized traffic, all compared
// against a run-length / deadline based reference model of the gating behaviour.
module tb_cg_ctrl;

    localparam int IDLE_N = 4;
    localparam int WAKE_N = 2;

    logic clk = 1'b0;
    logic rst_n, auto_en, force_on, idle, wake_req, sleep_ack;
    logic sleep_req, cg_en, gated, ready;

    int n_checks = 0;
    int n_errors = 0;

    // Model: operating mode, length of the current qualifying-idle run, wake deadline edge.
    localparam int M_RUN = 0, M_REQ = 1, M_GATED = 2, M_WAKE = 3;
    int m_mode = M_RUN;
    int m_run  = 0;
    int m_edge = 0;
    int m_wake_end = 0;

    cg_ctrl #(.IDLE_CYCLES(IDLE_N), .WAKE_CYCLES(WAKE_N)) dut (
        .clk(clk), .rst_n(rst_n), .auto_en(auto_en), .force_on(force_on), .idle(idle),
        .wake_req(wake_req), .sleep_ack(sleep_ack), .sleep_req(sleep_req), .cg_en(cg_en),
        .gated(gated), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {cg_en, sleep_req, gated, ready}: clock off only when asleep, request held
    // from the handshake until the settling window ends, ready only in normal running.
    function automatic logic [3:0] model_outs();
        logic c, s, g, r;
        c = (m_mode != M_GATED);
        s = (m_mode != M_RUN);
        g = (m_mode == M_GATED);
        r = (m_mode == M_RUN);
        return {c, s, g, r};
    endfunction

    task automatic tick(input string tag);
        logic q, ex;
        @(posedge clk);
        q  = auto_en & ~force_on & idle & ~wake_req;
        ex = wake_req | force_on | ~auto_en;
        m_edge++;
        if (!rst_n) begin
            m_mode = M_RUN;
            m_run  = 0;
        end else if (m_mode == M_RUN) begin
            m_run = q ? m_run + 1 : 0;
            if (m_run == IDLE_N) begin
                m_mode = M_REQ;
                m_run  = 0;
            end
        end else if (m_mode == M_REQ) begin
            if (!q) m_mode = M_RUN;
            else if (sleep_ack) m_mode = M_GATED;
        end else if (m_mode == M_GATED) begin
            if (ex) begin
                m_mode     = M_WAKE;
                m_wake_end = m_edge + WAKE_N;
            end
        end else if (m_edge == m_wake_end) begin
            m_mode = M_RUN;
            m_run  = 0;
        end
        #1;
        check(tag, {cg_en, sleep_req, gated, ready}, model_outs());
    endtask

    task automatic reset_for(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) tick("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; auto_en = 1'b0; force_on = 1'b0; idle = 1'b0;
        wake_req = 1'b0; sleep_ack = 1'b0;
        #2;

        // Reset and pass-through with auto gating disabled.
        reset_for(3);
        check("reset_vals", {cg_en, sleep_req, gated, ready}, 4'b1001);
        for (int i = 0; i < 20; i++) begin
            idle = 1'($urandom_range(0, 1));
            sleep_ack = 1'($urandom_range(0, 1));
            tick("passthru");
            check("passthru_on", {cg_en, sleep_req, ready}, 4'b0101);
        end

        // Sleep and wake with sleep_ack tied high.
        reset_for(1);
        auto_en = 1'b1; idle = 1'b1; sleep_ack = 1'b1;
        for (int i = 0; i < 3; i++) tick("sw_count");
        check("sw_sreq_c3", 4'(sleep_req), 4'd0);
        tick("sw_req");
        check("sw_sreq_c4", {cg_en, sleep_req}, 4'b0011);
        tick("sw_gate");
        check("sw_cgen_c5", 4'(cg_en), 4'd0);
        for (int i = 0; i < 5; i++) tick("sw_gated");
        wake_req = 1'b1;
        tick("sw_wake");
        wake_req = 1'b0;
        check("sw_cgen_c11", {cg_en, ready}, 4'b0010);
        tick("sw_settle");
        check("sw_ready_c12", 4'(ready), 4'd0);
        tick("sw_run");
        check("sw_ready_c13", {ready, sleep_req}, 4'b0010);

        // Single-cycle idle glitch restarts the count.
        reset_for(1);
        sleep_ack = 1'b0; idle = 1'b1;
        tick("gl_c0"); tick("gl_c1");
        idle = 1'b0; tick("gl_c2"); idle = 1'b1;
        for (int i = 0; i < 3; i++) tick("gl_cnt");
        check("gl_sreq_c6", 4'(sleep_req), 4'd0);
        tick("gl_req");
        check("gl_sreq_c7", 4'(sleep_req), 4'd1);

        // Abort beats acknowledge in REQ.
        sleep_ack = 1'b1; wake_req = 1'b1;
        tick("abort");
        check("abort_run", {cg_en, sleep_req, gated, ready}, 4'b1001);
        sleep_ack = 1'b0; wake_req = 1'b0;

        // Stall in REQ without acknowledge.
        for (int i = 0; i < IDLE_N; i++) tick("stall_cnt");
        for (int i = 0; i < 50; i++) begin
            tick("stall");
            check("stall_req", {cg_en, sleep_req, gated, ready}, 4'b1100);
        end

        // force_on while gated restores the clock on the next edge.
        sleep_ack = 1'b1;
        tick("fo_gate");
        check("fo_gated", 4'(gated), 4'd1);
        force_on = 1'b1;
        tick("fo_wake");
        force_on = 1'b0;
        check("fo_cgen", {cg_en, gated}, 4'b0010);

        // Re-gate, then reset while gated.
        for (int i = 0; i < 12; i++) tick("rg");
        check("rg_gated", {cg_en, gated}, 4'b0001);
        rst_n = 1'b0;
        tick("rst_gated");
        rst_n = 1'b1;
        check("rst_gated_out", {cg_en, sleep_req, gated, ready}, 4'b1001);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            auto_en   = ($urandom_range(0, 9) != 0);
            force_on  = ($urandom_range(0, 29) == 0);
            idle      = ($urandom_range(0, 9) != 0);
            wake_req  = ($urandom_range(0, 24) == 0);
            sleep_ack = ($urandom_range(0, 2) == 0);
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
